// File: rtl/adau_config_seq.sv
// ADAU1761 power-up configuration sequencer: walks a register/value table and
// writes each entry over an I2C master with NACK/timeout retries and delay entries.
module adau_config_seq #(
    parameter int unsigned NUM_ENTRIES = 16,
    parameter logic [6:0]  DEV_ADDR    = 7'h3B,
    parameter int unsigned MAX_RETRIES = 3,
    parameter int unsigned DELAY_UNIT  = 1000,
    parameter int unsigned RSP_TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [23:0] rom_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [6:0]  cmd_dev,
    output logic [15:0] cmd_reg,
    output logic [7:0]  cmd_data,
    input  logic        rsp_valid,
    input  logic        rsp_nack,
    output logic        busy,
    output logic        config_done,
    output logic        config_error,
    output logic        serdes_reset
);

    localparam int unsigned DLY_MAX = 255 * DELAY_UNIT;
    localparam int unsigned DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX + 1) : 1;
    localparam int unsigned TMO_W   = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT + 1) : 1;
    localparam int unsigned RTY_W   = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [7:0]       LAST_IDX   = 8'(NUM_ENTRIES - 1);
    localparam logic [DLY_W-1:0] DLY_UNIT_W = DLY_W'(DELAY_UNIT);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(RSP_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX    = RTY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, ISSUE, WAIT_RSP, DELAY, DONE, ERROR
    } state_t;

    state_t           state, state_n;
    logic [7:0]       index, index_n;
    logic [RTY_W-1:0] retry_cnt, retry_n;
    logic [DLY_W-1:0] delay_cnt, delay_n;
    logic [TMO_W-1:0] tmo_cnt, tmo_n;
    logic [15:0]      reg_n;
    logic [7:0]       data_n;
    logic             advance_c;
    logic             fail_c;

    assign rom_addr = index;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and datapath decisions
    always_comb begin
        state_n   = state;
        index_n   = index;
        retry_n   = retry_cnt;
        delay_n   = delay_cnt;
        tmo_n     = tmo_cnt;
        reg_n     = cmd_reg;
        data_n    = cmd_data;
        advance_c = 1'b0;
        fail_c    = 1'b0;

        unique case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_n = FETCH;
                    index_n = '0;
                    retry_n = '0;
                end
            end
            FETCH: state_n = DECODE;
            DECODE: begin
                if (rom_data[23:8] == 16'hFFFF) begin
                    delay_n = DLY_W'(rom_data[7:0]) * DLY_UNIT_W;
                    state_n = DELAY;
                end else begin
                    reg_n   = rom_data[23:8];
                    data_n  = rom_data[7:0];
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    tmo_n   = '0;
                    state_n = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // A response wins over a timeout landing in the same cycle
                if (rsp_valid) begin
                    advance_c = !rsp_nack;
                    fail_c    = rsp_nack;
                end else if (tmo_cnt == TMO_LAST) begin
                    fail_c = 1'b1;
                end else begin
                    tmo_n = tmo_cnt + TMO_W'(1);
                end
            end
            DELAY: begin
                if (delay_cnt == '0) begin
                    advance_c = 1'b1;
                end else begin
                    delay_n = delay_cnt - DLY_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        if (advance_c) begin
            retry_n = '0;
            if (index == LAST_IDX) begin
                state_n = DONE;
            end else begin
                index_n = index + 8'd1;
                state_n = FETCH;
            end
        end

        if (fail_c) begin
            if (retry_cnt < RTY_MAX) begin
                retry_n = retry_cnt + RTY_W'(1);
                state_n = ISSUE;
            end else begin
                state_n = ERROR;
            end
        end
    end

    // Datapath and registered outputs, decoded from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index        <= '0;
            retry_cnt    <= '0;
            delay_cnt    <= '0;
            tmo_cnt      <= '0;
            cmd_reg      <= '0;
            cmd_data     <= '0;
            cmd_dev      <= DEV_ADDR;
            cmd_valid    <= 1'b0;
            busy         <= 1'b0;
            config_done  <= 1'b0;
            config_error <= 1'b0;
            serdes_reset <= 1'b1;
        end else begin
            index        <= index_n;
            retry_cnt    <= retry_n;
            delay_cnt    <= delay_n;
            tmo_cnt      <= tmo_n;
            cmd_reg      <= reg_n;
            cmd_data     <= data_n;
            cmd_dev      <= DEV_ADDR;
            cmd_valid    <= (state_n == ISSUE);
            busy         <= !(state_n inside {IDLE, DONE, ERROR});
            config_done  <= (state_n == DONE);
            config_error <= (state_n == ERROR);
            serdes_reset <= (state_n != DONE);
        end
    end

endmodule

// File: tb/tb_adau_config_seq.sv
// Directed bench for adau_config_seq: synchronous table ROM, handshake logger,
// and a linear script acting as the I2C master.
module tb_adau_config_seq;

    localparam int RSP_TO = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data = '0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic [6:0]  cmd_dev;
    logic [15:0] cmd_reg;
    logic [7:0]  cmd_data;
    logic        rsp_valid = 1'b0;
    logic        rsp_nack = 1'b0;
    logic        busy;
    logic        config_done;
    logic        config_error;
    logic        serdes_reset;

    logic [23:0] rom_mem [0:255];
    logic [30:0] log_q [0:63];
    int          cmd_count = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    adau_config_seq #(
        .NUM_ENTRIES(3),
        .DEV_ADDR(7'h3B),
        .MAX_RETRIES(3),
        .DELAY_UNIT(10),
        .RSP_TIMEOUT(RSP_TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dev(cmd_dev),
        .cmd_reg(cmd_reg),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_nack(rsp_nack),
        .busy(busy),
        .config_done(config_done),
        .config_error(config_error),
        .serdes_reset(serdes_reset)
    );

    always #5 clk = ~clk;

    // Synchronous table ROM: data one cycle after the address
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // Log every accepted command
    always @(posedge clk) begin
        if (!reset && cmd_valid && cmd_ready) begin
            if (cmd_count < 64) log_q[cmd_count] = {cmd_dev, cmd_reg, cmd_data};
            cmd_count = cmd_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [23:0] e0, input logic [23:0] e1, input logic [23:0] e2);
        rom_mem[0] = e0;
        rom_mem[1] = e1;
        rom_mem[2] = e2;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_accept(input string tag, output int n);
        int c0;
        c0 = cmd_count;
        n = 0;
        while (cmd_count == c0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(cmd_count - c0), 32'd1);
    endtask

    task automatic send_rsp(input logic nack, input int gap);
        repeat (gap) @(negedge clk);
        rsp_valid = 1'b1;
        rsp_nack  = nack;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_nack  = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (!(config_done || config_error) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(config_done || config_error), 32'd1);
    endtask

    localparam logic [30:0] A0 = {7'h3B, 16'h4000, 8'h01};
    localparam logic [30:0] A1 = {7'h3B, 16'h4015, 8'h02};
    localparam logic [30:0] A2 = {7'h3B, 16'h4017, 8'h03};
    localparam logic [30:0] B0 = {7'h3B, 16'h4001, 8'hA5};
    localparam logic [30:0] B2 = {7'h3B, 16'h40F9, 8'h7F};

    initial begin
        int n;
        int c0;
        int dur;
        int bad;
        logic [15:0] r0;
        logic [7:0]  d0;

        for (int i = 0; i < 256; i++) rom_mem[i] = 24'h0;
        load(24'h400001, 24'h401502, 24'h401703);

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(config_done), 32'd0);
        chk("rst_error", 32'(config_error), 32'd0);
        chk("rst_serdes", 32'(serdes_reset), 32'd1);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Three entries, all ACKed
        c0 = cmd_count;
        pulse_start();
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_serdes", 32'(serdes_reset), 32'd1);
        for (int i = 0; i < 3; i++) begin
            wait_accept("t1_accept", n);
            send_rsp(1'b0, 2);
        end
        wait_end("t1_end");
        chk("t1_count", 32'(cmd_count - c0), 32'd3);
        chk("t1_cmd0", 32'(log_q[c0]), 32'(A0));
        chk("t1_cmd1", 32'(log_q[c0+1]), 32'(A1));
        chk("t1_cmd2", 32'(log_q[c0+2]), 32'(A2));
        chk("t1_done", 32'(config_done), 32'd1);
        chk("t1_serdes_rel", 32'(serdes_reset), 32'd0);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_error", 32'(config_error), 32'd0);

        // Stalled cmd_ready, delay entry, response injected during DELAY
        load(24'h4001A5, 24'hFFFF05, 24'h40F97F);
        cmd_ready = 1'b0;
        c0 = cmd_count;
        pulse_start();
        chk("t2_done_clr", 32'(config_done), 32'd0);
        n = 0;
        while (!cmd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t2_valid", 32'(cmd_valid), 32'd1);
        r0 = cmd_reg;
        d0 = cmd_data;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!cmd_valid || cmd_reg !== r0 || cmd_data !== d0 || cmd_dev !== 7'h3B) bad++;
        end
        chk("t2_stable", 32'(bad), 32'd0);
        chk("t2_no_accept", 32'(cmd_count - c0), 32'd0);
        cmd_ready = 1'b1;
        wait_accept("t2_accept0", n);
        chk("t2_cmd0", 32'(log_q[c0]), 32'(B0));
        send_rsp(1'b0, 1);
        dur = 0;
        while (rom_addr == 8'd1 && dur < 300) begin
            rsp_valid = (dur == 10);
            dur++;
            @(negedge clk);
        end
        rsp_valid = 1'b0;
        // FETCH + DECODE + 50..51 DELAY cycles
        chk("t2_delay_len", 32'(dur >= 52 && dur <= 53), 32'd1);
        chk("t2_no_cmd_delay", 32'(cmd_count - c0), 32'd1);
        chk("t2_next_idx", 32'(rom_addr), 32'd2);
        wait_accept("t2_accept2", n);
        chk("t2_cmd2", 32'(log_q[c0+1]), 32'(B2));
        send_rsp(1'b0, 3);
        wait_end("t2_end");
        chk("t2_done", 32'(config_done), 32'd1);
        chk("t2_count", 32'(cmd_count - c0), 32'd2);

        // Entry 0 NACKed twice, then ACKed
        load(24'h400001, 24'h401502, 24'h401703);
        c0 = cmd_count;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            wait_accept("t3_accept0", n);
            send_rsp(i < 2, 1);
        end
        chk("t3_retry0", 32'(log_q[c0]), 32'(A0));
        chk("t3_retry1", 32'(log_q[c0+1]), 32'(A0));
        chk("t3_retry2", 32'(log_q[c0+2]), 32'(A0));
        for (int i = 0; i < 2; i++) begin
            wait_accept("t3_accept", n);
            send_rsp(1'b0, 0);
        end
        wait_end("t3_end");
        chk("t3_cmd1", 32'(log_q[c0+3]), 32'(A1));
        chk("t3_cmd2", 32'(log_q[c0+4]), 32'(A2));
        chk("t3_done", 32'(config_done), 32'd1);

        // Response timeout triggers a re-issue
        c0 = cmd_count;
        pulse_start();
        wait_accept("t4_accept0", n);
        wait_accept("t4_retry", n);
        chk("t4_retry_gap", 32'(n >= RSP_TO && n <= RSP_TO + 3), 32'd1);
        chk("t4_retry_cmd", 32'(log_q[c0+1]), 32'(A0));
        send_rsp(1'b0, 0);
        for (int i = 0; i < 2; i++) begin
            wait_accept("t4_accept", n);
            send_rsp(1'b0, 0);
        end
        wait_end("t4_end");
        chk("t4_done", 32'(config_done), 32'd1);
        chk("t4_count", 32'(cmd_count - c0), 32'd4);

        // Entry 0 NACKed four times exhausts the retry budget
        c0 = cmd_count;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            wait_accept("t5_accept", n);
            send_rsp(1'b1, 1);
        end
        repeat (20) @(negedge clk);
        chk("t5_error", 32'(config_error), 32'd1);
        chk("t5_done", 32'(config_done), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_serdes", 32'(serdes_reset), 32'd1);
        chk("t5_count", 32'(cmd_count - c0), 32'd4);
        chk("t5_rom_addr", 32'(rom_addr), 32'd0);

        // Restart after ERROR, then reset while waiting for entry 1's response
        c0 = cmd_count;
        pulse_start();
        chk("t6_error_clr", 32'(config_error), 32'd0);
        chk("t6_busy", 32'(busy), 32'd1);
        wait_accept("t6_accept0", n);
        chk("t6_cmd0", 32'(log_q[c0]), 32'(A0));
        send_rsp(1'b0, 0);
        wait_accept("t6_accept1", n);
        chk("t6_rom_addr1", 32'(rom_addr), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_valid", 32'(cmd_valid), 32'd0);
        chk("t6_rst_done", 32'(config_done), 32'd0);
        chk("t6_rst_error", 32'(config_error), 32'd0);
        chk("t6_rst_serdes", 32'(serdes_reset), 32'd1);
        chk("t6_rst_rom_addr", 32'(rom_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        send_rsp(1'b0, 1);
        repeat (20) @(negedge clk);
        chk("t6_idle_busy", 32'(busy), 32'd0);
        chk("t6_idle_valid", 32'(cmd_valid), 32'd0);
        chk("t6_no_reissue", 32'(cmd_count - c0), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adau_config_seq.md
ADAU_CONFIG_SEQ -- requirements
Module: adau_config_seq

Interface
REQ-001 SHALL provide parameter NUM_ENTRIES, default 16, meaning the number of configuration table entries (range 1..256).
REQ-002 SHALL provide parameter DEV_ADDR, default 7'h3B, meaning the ADAU1761 7-bit I2C device address.
REQ-003 SHALL provide parameter MAX_RETRIES, default 3, meaning the number of re-issues allowed per entry after a NACK or timeout.
REQ-004 SHALL provide parameter DELAY_UNIT, default 1000, meaning clk cycles per delay-entry count.
REQ-005 SHALL provide parameter RSP_TIMEOUT, default 100000, meaning the maximum clk cycles to wait for a response.
REQ-006 SHALL provide port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL provide port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL provide port start, input, 1 bit: single-cycle pulse that begins the sequence.
REQ-009 SHALL provide port rom_addr, output, 8 bits: table index.
REQ-010 SHALL provide port rom_data, input, 24 bits: {reg_addr[15:0], value[7:0]}, valid one cycle after rom_addr.
REQ-011 SHALL provide port cmd_valid, output, 1 bit: I2C write request.
REQ-012 SHALL provide port cmd_ready, input, 1 bit: the I2C master accepts the request.
REQ-013 SHALL provide port cmd_dev, output, 7 bits: device address, always DEV_ADDR.
REQ-014 SHALL provide port cmd_reg, output, 16 bits: register address.
REQ-015 SHALL provide port cmd_data, output, 8 bits: register value.
REQ-016 SHALL provide port rsp_valid, input, 1 bit: the I2C transaction completed.
REQ-017 SHALL provide port rsp_nack, input, 1 bit: qualifies rsp_valid; 1 means the device did not acknowledge.
REQ-018 SHALL provide port busy, output, 1 bit: the sequence is in progress.
REQ-019 SHALL provide port config_done, output, 1 bit: all entries were written successfully.
REQ-020 SHALL provide port config_error, output, 1 bit: the retry budget was exhausted.
REQ-021 SHALL provide port serdes_reset, output, 1 bit: holds the I2S serdes in reset until the codec is configured.

Function
REQ-022 SHALL implement states IDLE, FETCH, DECODE, ISSUE, WAIT_RSP, DELAY, DONE and ERROR.
REQ-023 SHALL leave IDLE, DONE or ERROR for FETCH on start=1, setting index=0 and retry_cnt=0 and clearing config_done and config_error; start SHALL be ignored in all other states.
REQ-024 SHALL in FETCH drive rom_addr=index and go to DECODE the next cycle; rom_addr SHALL hold index in every state.
REQ-025 SHALL in DECODE go to DELAY if rom_data[23:8]==16'hFFFF, loading delay_cnt=rom_data[7:0]*DELAY_UNIT; otherwise it SHALL latch cmd_reg/cmd_data from rom_data and go to ISSUE.
REQ-026 SHALL size delay_cnt to hold 255*DELAY_UNIT without overflow, SHALL count it down in DELAY, and SHALL advance when it reaches 0; a count of 0 SHALL give a one-cycle DELAY.
REQ-027 SHALL assert cmd_valid only in ISSUE, with cmd_reg/cmd_data/cmd_dev held stable until the cmd_valid&&cmd_ready cycle, then go to WAIT_RSP with the timeout counter cleared.
REQ-028 SHALL in WAIT_RSP advance on rsp_valid&&!rsp_nack, and SHALL treat rsp_valid&&rsp_nack, or the timeout counter reaching RSP_TIMEOUT, as a failure.
REQ-029 SHALL on failure return to ISSUE with retry_cnt+1 if retry_cnt<MAX_RETRIES, and SHALL otherwise go to ERROR.
REQ-030 SHALL on advance clear retry_cnt and go to DONE if index==NUM_ENTRIES-1, otherwise increment index and go to FETCH.
REQ-031 SHALL ignore rsp_valid outside WAIT_RSP.
REQ-032 SHALL, if rsp_valid and the timeout occur in the same cycle, give rsp_valid priority.
REQ-033 SHALL drive busy=1 in every state except IDLE, DONE and ERROR.
REQ-034 SHALL drive config_done=1 only in DONE and config_error=1 only in ERROR.
REQ-035 SHALL drive serdes_reset=0 only in DONE.
REQ-036 SHALL register all outputs.

Reset
REQ-037 SHALL on reset=1, immediately and at any point mid-sequence, force state IDLE, index=0, retry_cnt=0, cmd_valid=0, busy=0, config_done=0, config_error=0 and serdes_reset=1; no pending command SHALL be re-issued after reset deasserts.

Verification
REQ-038 SHALL cover: NUM_ENTRIES=3, every response ACKed -> exactly 3 commands in table order, then config_done=1, serdes_reset=0 and busy=0.
REQ-039 SHALL cover: entry 1 = 24'hFFFF05 with DELAY_UNIT=10 -> no command for that entry and 50-51 cycles in DELAY before entry 2 is fetched.
REQ-040 SHALL cover: with MAX_RETRIES=3, entry 0 NACKed twice then ACKed -> 3 identical commands, then the sequence continues; entry 0 NACKed 4 times -> config_error=1 with no entry-1 command.
REQ-041 SHALL cover: cmd_ready held low 20 cycles -> cmd_valid and the fields stay stable throughout, and exactly one command is accepted.
REQ-042 SHALL cover: no rsp_valid for RSP_TIMEOUT cycles -> a retry is issued; rsp_valid injected while in DELAY -> ignored.
REQ-043 SHALL cover: reset pulsed while in WAIT_RSP -> all outputs at reset values that cycle; start after ERROR -> the sequence restarts from index 0 with flags cleared.
